// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl
// Lock supervisor and reset sequencer running on the free-running reference
// clock. It pulses the PLL reset, waits for lock, and requires lock to hold
// for a programmable time before releasing the downstream system reset.
// A lock loss while running re-asserts system reset and restarts the PLL.
// A lock timeout retries the PLL reset. Both events are counted in
// saturating statistics counters that only rst clears.
//
// All outputs are flops loaded from the next-state decode, so they follow
// the state register exactly and cannot glitch.

module pll_reset_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned CNT_W               = 17,
  parameter int unsigned STAT_W              = 8
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic              sys_rst,
  output logic              ready,
  output logic [1:0]        state,
  output logic [STAT_W-1:0] lock_loss_cnt,
  output logic [STAT_W-1:0] retry_cnt
);

  // The encoding is visible on the state port, so the values are fixed.
  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counts, pre-sized to the counter so the compares are exact.
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STAT_W-1:0] STAT_MAX    = {STAT_W{1'b1}};

  // Two-flop synchronizer; pll_locked comes from the PLL's own domain.
  logic [1:0] sync_reg;
  logic       locked_s;

  // Sequencer state and the single shared cycle counter.
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Event strobes from the decode into the statistics counters.
  logic retry_event;
  logic loss_event;

  // Registered outputs.
  logic              pll_rst_reg;
  logic              sys_rst_reg;
  logic              ready_reg;
  logic [STAT_W-1:0] lock_loss_reg;
  logic [STAT_W-1:0] retry_reg;

  // Bring pll_locked into the refclk domain; only the second stage is used.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], pll_locked};
    end
  end

  assign locked_s = sync_reg[1];

  // Next-state decode: every transition clears the shared counter.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    retry_event = 1'b0;
    loss_event  = 1'b0;

    unique case (state_reg)
      PLL_RESET: begin
        // Lock is deliberately ignored while the PLL is held in reset.
        if (cnt_reg == PULSE_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s) begin
          state_next = STABILIZE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next  = PLL_RESET;
          cnt_next    = '0;
          retry_event = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      STABILIZE: begin
        // A drop here is a failed qualification, not a loss: wait again
        // without re-pulsing the PLL.
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      RUN: begin
        // Counter parked at zero; any synchronized drop restarts the PLL.
        cnt_next = '0;
        if (!locked_s) begin
          state_next = PLL_RESET;
          loss_event = 1'b1;
        end
      end

      default: begin
        state_next = PLL_RESET;
        cnt_next   = '0;
      end
    endcase
  end

  // Sequencer registers: state, counter and outputs derived from next state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg   <= PLL_RESET;
      cnt_reg     <= '0;
      pll_rst_reg <= 1'b1;
      sys_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pll_rst_reg <= (state_next == PLL_RESET);
      sys_rst_reg <= (state_next != RUN);
      ready_reg   <= (state_next == RUN);
    end
  end

  // Saturating statistics: stick at all-ones rather than wrapping to zero.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_loss_reg <= '0;
      retry_reg     <= '0;
    end else begin
      if (loss_event && (lock_loss_reg != STAT_MAX)) begin
        lock_loss_reg <= lock_loss_reg + STAT_W'(1);
      end
      if (retry_event && (retry_reg != STAT_MAX)) begin
        retry_reg <= retry_reg + STAT_W'(1);
      end
    end
  end

  assign pll_rst       = pll_rst_reg;
  assign sys_rst       = sys_rst_reg;
  assign ready         = ready_reg;
  assign state         = state_reg;
  assign lock_loss_cnt = lock_loss_reg;
  assign retry_cnt     = retry_reg;

endmodule
